vga_pattern_engine: RTL and testbench

Parametrised VGA timing and test-pattern generator that replaces the fixed 640x480 decoder plus pattern pair. It produces sync, data-enable and pixel coordinates for any resolution, and renders one of several selectable patterns. Patterns include solid switch colour, colour bars, checkerboard, gradient, border and a bouncing box. Mode changes are applied only at frame boundaries to avoid tearing. It sits directly behind the board VGA DAC pins.

---
 rtl/vga_pattern_engine.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_vga_pattern_engine.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_engine.sv
// Parametrised VGA timing generator with selectable test patterns behind the board DAC pins.
// Optional feature: define VGA_PATTERN_BOX_EN to build the bouncing-box pattern (mode 5).
module vga_pattern_engine #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int COLOR_W  = 4,
    parameter int PIX_DIV  = 4,
    parameter int BOX_SIZE = 32
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [2:0]                                     mode,
    input  logic [COLOR_W-1:0]                             r_sw,
    input  logic [COLOR_W-1:0]                             g_sw,
    input  logic [COLOR_W-1:0]                             b_sw,
    output logic                                           h_sync,
    output logic                                           v_sync,
    output logic                                           DE,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]   pixel_x,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]   pixel_y,
    output logic [COLOR_W-1:0]                             r_port,
    output logic [COLOR_W-1:0]                             g_port,
    output logic [COLOR_W-1:0]                             b_port,
    output logic                                           frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);
    localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam int GW      = XW + COLOR_W;

    logic [DW-1:0]      div_q, div_d;
    logic [XW-1:0]      h_q, h_d;
    logic [YW-1:0]      v_q, v_d;
    logic [2:0]         mode_q, mode_d;
    logic               h_sync_q, h_sync_d;
    logic               v_sync_q, v_sync_d;
    logic               de_q, de_d;
    logic [XW-1:0]      px_q, px_d;
    logic [YW-1:0]      py_q, py_d;
    logic [COLOR_W-1:0] r_q, r_d;
    logic [COLOR_W-1:0] g_q, g_d;
    logic [COLOR_W-1:0] b_q, b_d;
    logic               fs_q, fs_d;

    logic               tick;
    logic               frame_tick;
    logic               h_last;
    logic               v_last;
    logic               visible;
    logic               in_box;

    logic [XW-1:0]      bar_raw;
    logic [2:0]         bar_idx;
    logic [COLOR_W-1:0] grey;
    logic               checker_on;
    logic               border_on;
    logic [COLOR_W-1:0] pat_r, pat_g, pat_b;

    // Pixel divider and raster counters.
    always_comb begin
        div_d      = div_q;
        h_d        = h_q;
        v_d        = v_q;
        tick       = (div_q == DW'(PIX_DIV - 1));
        h_last     = (h_q == XW'(H_TOTAL - 1));
        v_last     = (v_q == YW'(V_TOTAL - 1));
        frame_tick = tick && (h_q == '0) && (v_q == '0);
        if (tick) begin
            div_d = '0;
            h_d   = h_last ? '0 : h_q + XW'(1);
            if (h_last) begin
                v_d = v_last ? '0 : v_q + YW'(1);
            end
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    // The new mode already applies to pixel (0,0) so a whole frame uses one pattern.
    always_comb begin
        mode_d = mode_q;
        if (frame_tick) begin
            mode_d = mode;
        end
    end

`ifdef VGA_PATTERN_BOX_EN
    localparam int BX_MAX = H_ACTIVE - BOX_SIZE;
    localparam int BY_MAX = V_ACTIVE - BOX_SIZE;

    logic [XW-1:0] bx_q, bx_d;
    logic [YW-1:0] by_q, by_d;
    logic          dx_q, dx_d;
    logic          dy_q, dy_d;

    // Reaching an edge flips direction and steps back in the same frame, so there is no dwell.
    always_comb begin
        bx_d = bx_q;
        by_d = by_q;
        dx_d = dx_q;
        dy_d = dy_q;
        if (frame_tick) begin
            if (dx_q) begin
                if (bx_q >= XW'(BX_MAX)) begin
                    dx_d = 1'b0;
                    bx_d = bx_q - XW'(1);
                end else begin
                    bx_d = bx_q + XW'(1);
                end
            end else begin
                if (bx_q == '0) begin
                    dx_d = 1'b1;
                    bx_d = bx_q + XW'(1);
                end else begin
                    bx_d = bx_q - XW'(1);
                end
            end
            if (dy_q) begin
                if (by_q >= YW'(BY_MAX)) begin
                    dy_d = 1'b0;
                    by_d = by_q - YW'(1);
                end else begin
                    by_d = by_q + YW'(1);
                end
            end else begin
                if (by_q == '0) begin
                    dy_d = 1'b1;
                    by_d = by_q + YW'(1);
                end else begin
                    by_d = by_q - YW'(1);
                end
            end
        end
    end

    always_comb begin
        in_box = (h_q >= bx_d) && (h_q < bx_d + XW'(BOX_SIZE)) &&
                 (v_q >= by_d) && (v_q < by_d + YW'(BOX_SIZE));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bx_q <= '0;
            by_q <= '0;
            dx_q <= 1'b1;
            dy_q <= 1'b1;
        end else begin
            bx_q <= bx_d;
            by_q <= by_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end
`else
    always_comb begin
        in_box = 1'b0;
    end
`endif

    always_comb begin
        bar_raw    = h_q / XW'(BAR_W);
        bar_idx    = (bar_raw > XW'(7)) ? 3'd7 : bar_raw[2:0];
        grey       = COLOR_W'({h_q, {COLOR_W{1'b0}}} / GW'(H_ACTIVE));
        checker_on = ((h_q & XW'(32)) != '0) ^ ((v_q & YW'(32)) != '0);
        border_on  = (h_q == '0) || (h_q == XW'(H_ACTIVE - 1)) ||
                     (v_q == '0) || (v_q == YW'(V_ACTIVE - 1));
        visible    = (h_q < XW'(H_ACTIVE)) && (v_q < YW'(V_ACTIVE));
    end

    // Bar colours: red on bars 0,1,4,5; green on 0-3; blue on even bars.
    always_comb begin
        pat_r = '0;
        pat_g = '0;
        pat_b = '0;
        case (mode_d)
            3'd0: begin
                pat_r = r_sw;
                pat_g = g_sw;
                pat_b = b_sw;
            end
            3'd1: begin
                pat_r = {COLOR_W{~bar_idx[1]}};
                pat_g = {COLOR_W{~bar_idx[2]}};
                pat_b = {COLOR_W{~bar_idx[0]}};
            end
            3'd2: begin
                pat_r = {COLOR_W{checker_on}};
                pat_g = {COLOR_W{checker_on}};
                pat_b = {COLOR_W{checker_on}};
            end
            3'd3: begin
                pat_r = grey;
                pat_g = grey;
                pat_b = grey;
            end
            3'd4: begin
                pat_r = {COLOR_W{border_on}};
                pat_g = {COLOR_W{border_on}};
                pat_b = {COLOR_W{border_on}};
            end
`ifdef VGA_PATTERN_BOX_EN
            3'd5: begin
                pat_r = {COLOR_W{in_box}};
                pat_g = {COLOR_W{in_box}};
                pat_b = '1;
            end
`endif
            default: begin
                pat_r = '0;
                pat_g = '0;
                pat_b = '0;
            end
        endcase
    end

    // Outputs show the counter state from before the tick, all on the same edge.
    always_comb begin
        h_sync_d = h_sync_q;
        v_sync_d = v_sync_q;
        de_d     = de_q;
        px_d     = px_q;
        py_d     = py_q;
        r_d      = r_q;
        g_d      = g_q;
        b_d      = b_q;
        fs_d     = frame_tick;
        if (tick) begin
            h_sync_d = !((h_q >= XW'(H_ACTIVE + H_FP)) &&
                         (h_q <= XW'(H_ACTIVE + H_FP + H_SYNC - 1)));
            v_sync_d = !((v_q >= YW'(V_ACTIVE + V_FP)) &&
                         (v_q <= YW'(V_ACTIVE + V_FP + V_SYNC - 1)));
            de_d     = visible;
            px_d     = h_q;
            py_d     = v_q;
            r_d      = visible ? pat_r : '0;
            g_d      = visible ? pat_g : '0;
            b_d      = visible ? pat_b : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q    <= '0;
            h_q      <= '0;
            v_q      <= '0;
            mode_q   <= '0;
            h_sync_q <= 1'b1;
            v_sync_q <= 1'b1;
            de_q     <= 1'b0;
            px_q     <= '0;
            py_q     <= '0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            fs_q     <= 1'b0;
        end else begin
            div_q    <= div_d;
            h_q      <= h_d;
            v_q      <= v_d;
            mode_q   <= mode_d;
            h_sync_q <= h_sync_d;
            v_sync_q <= v_sync_d;
            de_q     <= de_d;
            px_q     <= px_d;
            py_q     <= py_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            fs_q     <= fs_d;
        end
    end

    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign DE          = de_q;
    assign pixel_x     = px_q;
    assign pixel_y     = py_q;
    assign r_port      = r_q;
    assign g_port      = g_q;
    assign b_port      = b_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_pattern_engine.sv
// Bench for vga_pattern_engine on a reduced 40x36 raster (44x40 total, 2 clk per pixel).
// Model tracks pixel time since reset release; directed points pin the model with literals.
`timescale 1ns/1ps
module tb_vga_pattern_engine;

    localparam int H_ACTIVE = 40;
    localparam int H_FP     = 1;
    localparam int H_SYNC   = 2;
    localparam int H_BP     = 1;
    localparam int V_ACTIVE = 36;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam int COLOR_W  = 4;
    localparam int PIX_DIV  = 2;
    localparam int BOX_SIZE = 32;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = H_TOTAL * V_TOTAL;
    localparam int BX_MAX   = H_ACTIVE - BOX_SIZE;
    localparam int BY_MAX   = V_ACTIVE - BOX_SIZE;

`ifdef VGA_PATTERN_BOX_EN
    localparam int BOX_IN  = 'hFFF;
    localparam int BOX_OUT = 'h00F;
`else
    localparam int BOX_IN  = 0;
    localparam int BOX_OUT = 0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [2:0]   mode = 3'd1;
    logic [3:0]   r_sw = 4'h0;
    logic [3:0]   g_sw = 4'h0;
    logic [3:0]   b_sw = 4'h0;
    logic         h_sync, v_sync, DE, frame_start;
    logic [5:0]   pixel_x, pixel_y;
    logic [3:0]   r_port, g_port, b_port;

    int checks = 0;
    int failures = 0;
    int edges = 0;
    int frame_mode = 0;

    always #5 clk = ~clk;

    vga_pattern_engine #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .COLOR_W(COLOR_W), .PIX_DIV(PIX_DIV), .BOX_SIZE(BOX_SIZE)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode),
        .r_sw(r_sw), .g_sw(g_sw), .b_sw(b_sw),
        .h_sync(h_sync), .v_sync(v_sync), .DE(DE),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .r_port(r_port), .g_port(g_port), .b_port(b_port),
        .frame_start(frame_start)
    );

    task automatic check_val(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Box position as a triangle wave over frames since reset.
    function automatic int tri_wave(input int f, input int lim);
        int m;
        if (lim <= 0) return 0;
        m = f % (2 * lim);
        return (m <= lim) ? m : 2 * lim - m;
    endfunction

    function automatic logic [11:0] model_rgb(input int md, input int x, input int y, input int f);
        int idx;
        logic [2:0] c;
        logic [3:0] gl;
        int bx, by;
        if (x >= H_ACTIVE || y >= V_ACTIVE) return 12'h000;
        case (md)
            0: return {r_sw, g_sw, b_sw};
            1: begin
                idx = x / (H_ACTIVE / 8);
                if (idx > 7) idx = 7;
                case (idx)
                    0: c = 3'b111;
                    1: c = 3'b110;
                    2: c = 3'b011;
                    3: c = 3'b010;
                    4: c = 3'b101;
                    5: c = 3'b100;
                    6: c = 3'b001;
                    default: c = 3'b000;
                endcase
                return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
            end
            2: return (((x / 32) % 2) != ((y / 32) % 2)) ? 12'hFFF : 12'h000;
            3: begin
                gl = 4'((x * 16) / H_ACTIVE);
                return {gl, gl, gl};
            end
            4: return (x == 0 || x == H_ACTIVE - 1 || y == 0 || y == V_ACTIVE - 1) ? 12'hFFF : 12'h000;
            5: begin
                bx = tri_wave(f, BX_MAX);
                by = tri_wave(f, BY_MAX);
                if (x >= bx && x < bx + BOX_SIZE && y >= by && y < by + BOX_SIZE) return 12'(BOX_IN);
                return 12'(BOX_OUT);
            end
            default: return 12'h000;
        endcase
    endfunction

    // Model time base: clock edges since reset release, and the mode captured at each frame start.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            edges = 0;
            frame_mode = 0;
        end else begin
            edges++;
            if ((edges % PIX_DIV == 0) && ((edges / PIX_DIV - 1) % FRAME == 0))
                frame_mode = int'(mode);
        end
    end

    always @(negedge clk) begin : compare
        logic [27:0] exp_v, act_v;
        int t, p, x, y, f;
        act_v = {h_sync, v_sync, DE, pixel_x, pixel_y, r_port, g_port, b_port, frame_start};
        if (!reset || edges < PIX_DIV) begin
            exp_v = {1'b1, 1'b1, 1'b0, 6'd0, 6'd0, 12'd0, 1'b0};
        end else begin
            t = edges / PIX_DIV - 1;
            p = t % FRAME;
            x = p % H_TOTAL;
            y = p / H_TOTAL;
            f = t / FRAME + 1;
            exp_v = {!(x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC),
                     !(y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC),
                     (x < H_ACTIVE && y < V_ACTIVE),
                     6'(x), 6'(y), model_rgb(frame_mode, x, y, f),
                     ((edges % PIX_DIV == 0) && (p == 0))};
        end
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("[TB] FAIL model_cmp edge=%0d actual=%h required=%h", edges, act_v, exp_v);
        end
    end

    // Waits until the model says pixel (x,y) of frame f (0 = any frame) was just presented.
    task automatic wait_pix(input int f, input int x, input int y);
        int budget;
        int t, p;
        bit hit;
        budget = 12 * FRAME * PIX_DIV;
        hit = 1'b0;
        while (!hit && budget > 0) begin
            @(negedge clk);
            budget--;
            if (reset && edges >= PIX_DIV && edges % PIX_DIV == 0) begin
                t = edges / PIX_DIV - 1;
                p = t % FRAME;
                if (p % H_TOTAL == x && p / H_TOTAL == y && (f == 0 || t / FRAME + 1 == f))
                    hit = 1'b1;
            end
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("[TB] FAIL wait_pix frame=%0d x=%0d y=%0d actual=timeout required=reached", f, x, y);
        end
    endtask

    function automatic int rgb();
        return int'({r_port, g_port, b_port});
    endfunction

    task automatic apply_stimulus();
        #1 reset = 1'b0;
        repeat (10) @(negedge clk);
        check_val("rst_hsync", int'(h_sync), 1);
        check_val("rst_vsync", int'(v_sync), 1);
        check_val("rst_de", int'(DE), 0);
        check_val("rst_xy", int'({pixel_x, pixel_y}), 0);
        check_val("rst_rgb", rgb(), 0);
        check_val("rst_fs", int'(frame_start), 0);
        #2 reset = 1'b1;

        // Frame 1: colour bars and sync timing.
        wait_pix(1, 0, 0);
        check_val("first_fs", int'(frame_start), 1);
        wait_pix(1, 0, 3);  check_val("bar_x0", rgb(), 'hFFF);
        wait_pix(1, 5, 3);  check_val("bar_x5", rgb(), 'hFF0);
        wait_pix(1, 39, 3); check_val("bar_x39", rgb(), 'h000);
        wait_pix(1, 40, 3);
        check_val("blank_de", int'(DE), 0);
        check_val("blank_rgb", rgb(), 0);
        check_val("hs_before", int'(h_sync), 1);
        wait_pix(1, 41, 3); check_val("hs_low", int'(h_sync), 0);
        wait_pix(1, 43, 3); check_val("hs_after", int'(h_sync), 1);
        wait_pix(1, 0, 37); check_val("vs_low", int'(v_sync), 0);
        mode = 3'd0; r_sw = 4'hA; g_sw = 4'h3; b_sw = 4'h5;

        // Frame 2: solid colour; mid-frame switch must not take effect until frame 3.
        wait_pix(2, 0, 18);
        mode = 3'd2;
        wait_pix(2, 5, 20); check_val("latch_solid", rgb(), 'hA35);
        wait_pix(3, 0, 0);
        check_val("chk_fs", int'(frame_start), 1);
        check_val("chk_00", rgb(), 'h000);
        wait_pix(3, 32, 0);  check_val("chk_32_0", rgb(), 'hFFF);
        wait_pix(3, 0, 32);  check_val("chk_0_32", rgb(), 'hFFF);
        wait_pix(3, 32, 32); check_val("chk_32_32", rgb(), 'h000);
        mode = 3'd3;

        wait_pix(4, 3, 1);  check_val("grad_3", rgb(), 'h111);
        wait_pix(4, 20, 1); check_val("grad_20", rgb(), 'h888);
        wait_pix(4, 39, 1); check_val("grad_39", rgb(), 'hFFF);
        mode = 3'd4;

        wait_pix(5, 0, 10);  check_val("brd_left", rgb(), 'hFFF);
        wait_pix(5, 1, 10);  check_val("brd_in", rgb(), 'h000);
        wait_pix(5, 20, 34); check_val("brd_y34", rgb(), 'h000);
        wait_pix(5, 20, 35); check_val("brd_bottom", rgb(), 'hFFF);
        mode = 3'd5;

        // Frames 6-9: box reaches bx=8 at frame 8 and steps back at frame 9; by bounces off 0.
        wait_pix(8, 7, 0); check_val("box_f8_x7", rgb(), BOX_OUT);
        wait_pix(8, 8, 0); check_val("box_f8_x8", rgb(), BOX_IN);
        wait_pix(9, 7, 0); check_val("box_f9_y0", rgb(), BOX_OUT);
        wait_pix(9, 6, 1); check_val("box_f9_x6", rgb(), BOX_OUT);
        wait_pix(9, 7, 1); check_val("box_f9_x7", rgb(), BOX_IN);
        mode = 3'd0;

        // Frame 10: asynchronous reset in the middle of a line.
        wait_pix(10, 20, 5);
        check_val("pre_rst_de", int'(DE), 1);
        check_val("pre_rst_rgb", rgb(), 'hA35);
        #2 reset = 1'b0;
        #1;
        check_val("async_de", int'(DE), 0);
        check_val("async_x", int'(pixel_x), 0);
        check_val("async_rgb", rgb(), 0);
        repeat (3) @(negedge clk);
        mode = 3'd1;
        #2 reset = 1'b1;
        wait_pix(1, 0, 0);
        check_val("restart_fs", int'(frame_start), 1);
        check_val("restart_xy", int'({pixel_x, pixel_y}), 0);
        check_val("restart_rgb", rgb(), 'hFFF);
    endtask

    initial begin
        $display("[TB] start");
        apply_stimulus();
        repeat (10) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
